csr_access_unit: RTL and testbench
==================================

Name: csr_access_unit

Overview:
Sequencer between the execute stage and the CSR register file. It accepts one Zicsr instruction (CSRRW/S/C and their immediate forms) per handshake and drives the CSR file's read/write strobes in separate cycles. It computes the read-modify-write value and returns the old CSR value (destined for rd) plus an illegal-instruction flag to the pipeline.

Parameters:
XLEN, 32, data width; must equal the CSR file's XLEN (taken from tcore_param).

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  1  request present
req_ready_o  out  1  unit can accept a request (high only in IDLE)
req_funct3_i  in  3  Zicsr funct3
req_addr_i  in  12  CSR index
req_rs1_data_i  in  XLEN  rs1 value (register forms)
req_rs1_field_i  in  5  rs1 index / zimm field
req_rd_zero_i  in  1  destination is x0
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  pipeline takes the response
rsp_rdata_o  out  XLEN  old CSR value for rd
rsp_illegal_o  out  1  illegal CSR instruction
csr_rd_en_o  out  1  CSR file read strobe
csr_wr_en_o  out  1  CSR file write strobe
csr_idx_o  out  12  CSR index to the file
csr_wdata_o  out  XLEN  write data to the file
csr_rdata_i  in  XLEN  combinational read data from the file

Behaviour:
- Reset (rst_i high at a clk_i edge): state=IDLE; req_ready_o=1; rsp_valid_o, csr_rd_en_o, csr_wr_en_o, rsp_illegal_o = 0; rsp_rdata_o, csr_idx_o, csr_wdata_o = 0. Reset mid-transaction aborts it and issues no write.
- States: IDLE, READ, WRITE, RESP.
- IDLE: when req_valid_i && req_ready_o, latch funct3, addr, operand and rd_zero, then go to READ. The operand is rs1_data when funct3[2]=0, otherwise zero-extended rs1_field.
- READ (1 cycle): csr_idx_o=addr. csr_rd_en_o=1 unless (op is RW/RWI && rd_zero). Capture csr_rdata_i into old; old=0 if the read is suppressed. Compute new value:
  - RW: new = operand
  - RS: new = old | operand
  - RC: new = old & ~operand
- Write decision: RW/RWI always write. RS/RC/RSI/RCI write only when rs1_field != 0. Write needed -> WRITE, else -> RESP.
- WRITE (1 cycle): csr_wr_en_o=1, csr_wdata_o=new, csr_idx_o=addr. Then go to RESP.
- RESP: rsp_valid_o=1 with rsp_rdata_o=old. Hold all response outputs stable until rsp_ready_i; on the handshake go to IDLE.
- Latency from accept edge to rsp_valid_o: 3 cycles with a write, 2 cycles without.
- funct3 of 000 or 100: still visits READ with no strobes, skips WRITE, responds with rsp_illegal_o=1 and rsp_rdata_o=0.
- Strobes are never asserted outside READ/WRITE. Only one of csr_rd_en_o / csr_wr_en_o is high in any cycle.
- Back-to-back: the earliest next accept is the cycle after the RESP handshake. There is no accept in the same cycle as a response.

Optional Feature:
CSR_ACCESS_CHECK_EN:
- Defined: illegal if a write is needed and addr[11:10]==2'b11 (read-only space). Also illegal if addr is not in the implemented set: F11–F14, 300, 301, 304, 305, 340–344, B00, B80, B02, BB2, 320.
- An illegal request asserts no strobes and responds with rsp_illegal_o=1 and rdata=0.
- Undefined: only the funct3 check applies; any address passes through to the CSR file.

Decomposition:
- In tcore_param: the CSR address localparams (currently private to the CSR file) and a csr_op_e enum of funct3 encodings; both modules share them.
- In this module: the state enum csr_acc_state_e.
- No sub-module needed. The RMW computation is a small always_comb in the same file.

Test Plan:
1. CSR file preloaded with mscratch=0x0000_00F0; CSRRS addr 0x340 with rs1_data=0x0F and rs1_field=5 -> rsp_rdata_o=0xF0; write of 0xFF on the WRITE cycle; rsp_valid_o 3 cycles after accept.
2. CSRRC addr 0x340 with rs1_field=0 -> rsp_rdata_o=0xF0; csr_wr_en_o never asserted; latency 2 cycles.
3. CSRRWI addr 0x305 with zimm=0x1F and rd_zero=1 -> csr_rd_en_o stays 0; csr_wdata_o=0x1F; rsp_rdata_o=0.
4. Hold rsp_ready_i=0 for 5 cycles in RESP -> outputs stable, req_ready_o=0; take the response, then immediately issue the next request -> accepted the following cycle.
5. Assert rst_i during READ of a CSRRW -> no csr_wr_en_o pulse; all outputs at reset values the next cycle.
6. With CSR_ACCESS_CHECK_EN: CSRRW to 0xF11 -> rsp_illegal_o=1, no strobes. Without the macro -> write strobe issued, rsp_illegal_o=0. Both builds: funct3=100 -> rsp_illegal_o=1.

Source files
------------

// File: rtl/csr_access_unit_pkg.sv
// Shared CSR definitions for the CSR access unit and the CSR register file.
// Contents: data width, field widths, Zicsr funct3 encodings (csr_op_e),
// implemented CSR addresses and a helper that tells whether an address is implemented.
package csr_access_unit_pkg;

  localparam int unsigned TCORE_XLEN  = 32;
  localparam int unsigned CSR_ADDR_W  = 12;
  localparam int unsigned FUNCT3_W    = 3;
  localparam int unsigned RS1_FIELD_W = 5;

  // Zicsr funct3 encodings; 000 and 100 are not CSR instructions
  typedef enum logic [FUNCT3_W-1:0] {
    CSR_OP_ILL0 = 3'b000,
    CSR_OP_RW   = 3'b001,
    CSR_OP_RS   = 3'b010,
    CSR_OP_RC   = 3'b011,
    CSR_OP_ILL1 = 3'b100,
    CSR_OP_RWI  = 3'b101,
    CSR_OP_RSI  = 3'b110,
    CSR_OP_RCI  = 3'b111
  } csr_op_e;

  localparam logic [CSR_ADDR_W-1:0] CSR_MVENDORID    = 12'hF11;
  localparam logic [CSR_ADDR_W-1:0] CSR_MARCHID      = 12'hF12;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIMPID       = 12'hF13;
  localparam logic [CSR_ADDR_W-1:0] CSR_MHARTID      = 12'hF14;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS      = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MISA         = 12'h301;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIE          = 12'h304;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC        = 12'h305;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCOUNTINHIB  = 12'h320;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH     = 12'h340;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC         = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE       = 12'h342;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL        = 12'h343;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIP          = 12'h344;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE       = 12'hB00;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET     = 12'hB02;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH      = 12'hB80;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCUSTOM_BB2  = 12'hBB2;

  // True when the CSR file implements the given address
  function automatic logic csr_implemented(input logic [CSR_ADDR_W-1:0] addr);
    case (addr)
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID,
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MCOUNTINHIB,
      CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP,
      CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MCUSTOM_BB2:
        csr_implemented = 1'b1;
      default:
        csr_implemented = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Bus bundle between pipeline, CSR access unit and CSR register file.
// slave  : the access unit (takes requests, drives strobes and responses)
// master : the pipeline plus CSR file side (drives requests, rsp_ready, read data)
interface csr_access_unit_if #(
  parameter int unsigned XLEN = csr_access_unit_pkg::TCORE_XLEN
) ();
  logic                                         req_valid_i;
  logic                                         req_ready_o;
  logic [csr_access_unit_pkg::FUNCT3_W-1:0]     req_funct3_i;
  logic [csr_access_unit_pkg::CSR_ADDR_W-1:0]   req_addr_i;
  logic [XLEN-1:0]                              req_rs1_data_i;
  logic [csr_access_unit_pkg::RS1_FIELD_W-1:0]  req_rs1_field_i;
  logic                                         req_rd_zero_i;
  logic                                         rsp_valid_o;
  logic                                         rsp_ready_i;
  logic [XLEN-1:0]                              rsp_rdata_o;
  logic                                         rsp_illegal_o;
  logic                                         csr_rd_en_o;
  logic                                         csr_wr_en_o;
  logic [csr_access_unit_pkg::CSR_ADDR_W-1:0]   csr_idx_o;
  logic [XLEN-1:0]                              csr_wdata_o;
  logic [XLEN-1:0]                              csr_rdata_i;

  modport slave (
    input  req_valid_i, req_funct3_i, req_addr_i, req_rs1_data_i,
           req_rs1_field_i, req_rd_zero_i, rsp_ready_i, csr_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_illegal_o,
           csr_rd_en_o, csr_wr_en_o, csr_idx_o, csr_wdata_o
  );

  modport master (
    output req_valid_i, req_funct3_i, req_addr_i, req_rs1_data_i,
           req_rs1_field_i, req_rd_zero_i, rsp_ready_i, csr_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_illegal_o,
           csr_rd_en_o, csr_wr_en_o, csr_idx_o, csr_wdata_o
  );
endinterface

// File: rtl/csr_access_unit.sv
// CSR access unit: sequences one Zicsr instruction at a time into separate
// read and write cycles on the CSR file, returns the old CSR value and an
// illegal-instruction flag.
// Ports: clk_i, rst_i (synchronous, active high), bus_if (csr_access_unit_if.slave:
//   req_* request handshake, rsp_* response handshake, csr_* CSR file strobes/data).
// Build option: CSR_ACCESS_CHECK_EN adds address legality checks
//   (unimplemented CSR, or write to read-only space 0xC00-0xFFF).
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int unsigned XLEN = TCORE_XLEN
) (
  input  logic               clk_i,
  input  logic               rst_i,
  csr_access_unit_if.slave   bus_if
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } csr_acc_state_e;

  csr_acc_state_e             state_q;
  csr_op_e                    op_q;
  logic [XLEN-1:0]            operand_q;
  logic [XLEN-1:0]            old_q;
  logic                       wr_need_q;
  logic                       illegal_q;
  logic                       req_ready_q;
  logic                       rsp_valid_q;
  logic [XLEN-1:0]            rsp_rdata_q;
  logic                       rsp_illegal_q;
  logic                       csr_rd_en_q;
  logic                       csr_wr_en_q;
  logic [CSR_ADDR_W-1:0]      csr_idx_q;
  logic [XLEN-1:0]            csr_wdata_q;

  // Request decode, evaluated on the incoming request in IDLE
  csr_op_e                    req_op;
  logic                       req_funct3_bad;
  logic                       req_is_rw;
  logic                       req_wr_need;
  logic                       req_rd_supp;
  logic                       req_illegal;
  logic [XLEN-1:0]            req_operand;

  always_comb begin
    req_op         = csr_op_e'(bus_if.req_funct3_i);
    req_funct3_bad = (bus_if.req_funct3_i[1:0] == 2'b00);
    req_is_rw      = (bus_if.req_funct3_i[1:0] == 2'b01);
    // set/clear with a zero rs1/zimm field leave the CSR untouched
    req_wr_need    = !req_funct3_bad && (req_is_rw || (bus_if.req_rs1_field_i != '0));
    req_rd_supp    = req_is_rw && bus_if.req_rd_zero_i;
    req_operand    = bus_if.req_funct3_i[2] ? XLEN'(bus_if.req_rs1_field_i)
                                            : bus_if.req_rs1_data_i;
`ifdef CSR_ACCESS_CHECK_EN
    req_illegal    = req_funct3_bad
                   || !csr_implemented(bus_if.req_addr_i)
                   || (req_wr_need && (bus_if.req_addr_i[11:10] == 2'b11));
`else
    req_illegal    = req_funct3_bad;
`endif
  end

  // Read-modify-write value; a suppressed read contributes zero
  logic [XLEN-1:0] old_c;
  logic [XLEN-1:0] new_c;

  always_comb begin
    old_c = csr_rd_en_q ? bus_if.csr_rdata_i : '0;
    case (op_q)
      CSR_OP_RW, CSR_OP_RWI: new_c = operand_q;
      CSR_OP_RS, CSR_OP_RSI: new_c = old_c | operand_q;
      CSR_OP_RC, CSR_OP_RCI: new_c = old_c & ~operand_q;
      default:               new_c = '0;
    endcase
  end

  // Sequencer with registered strobes and response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      op_q          <= CSR_OP_ILL0;
      operand_q     <= '0;
      old_q         <= '0;
      wr_need_q     <= 1'b0;
      illegal_q     <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_illegal_q <= 1'b0;
      csr_rd_en_q   <= 1'b0;
      csr_wr_en_q   <= 1'b0;
      csr_idx_q     <= '0;
      csr_wdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_if.req_valid_i && req_ready_q) begin
            state_q     <= ST_READ;
            req_ready_q <= 1'b0;
            op_q        <= req_op;
            operand_q   <= req_operand;
            wr_need_q   <= req_wr_need && !req_illegal;
            illegal_q   <= req_illegal;
            csr_idx_q   <= bus_if.req_addr_i;
            // strobe must already be high during the READ cycle
            csr_rd_en_q <= !req_illegal && !req_rd_supp;
          end
        end
        ST_READ: begin
          csr_rd_en_q <= 1'b0;
          old_q       <= old_c;
          if (wr_need_q) begin
            state_q     <= ST_WRITE;
            csr_wr_en_q <= 1'b1;
            csr_wdata_q <= new_c;
          end else begin
            state_q       <= ST_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= old_c;
            rsp_illegal_q <= illegal_q;
          end
        end
        ST_WRITE: begin
          state_q       <= ST_RESP;
          csr_wr_en_q   <= 1'b0;
          rsp_valid_q   <= 1'b1;
          rsp_rdata_q   <= old_q;
          rsp_illegal_q <= illegal_q;
        end
        ST_RESP: begin
          if (bus_if.rsp_ready_i) begin
            state_q       <= ST_IDLE;
            rsp_valid_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            req_ready_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_if.req_ready_o   = req_ready_q;
  assign bus_if.rsp_valid_o   = rsp_valid_q;
  assign bus_if.rsp_rdata_o   = rsp_rdata_q;
  assign bus_if.rsp_illegal_o = rsp_illegal_q;
  assign bus_if.csr_rd_en_o   = csr_rd_en_q;
  assign bus_if.csr_wr_en_o   = csr_wr_en_q;
  assign bus_if.csr_idx_o     = csr_idx_q;
  assign bus_if.csr_wdata_o   = csr_wdata_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Testbench for csr_access_unit: directed Zicsr transactions against a CSR
// file model, with a transaction-level expectation model checked every cycle.
// Honours CSR_ACCESS_CHECK_EN the same way as the design.
module tb_csr_access_unit;

  logic clk;
  logic rst;
  logic preload;
  logic chk_en;
  int   checks;
  int   errors;
  int   rd_cnt;
  int   wr_cnt;
  logic [31:0] last_wdata;

  csr_access_unit_if #(.XLEN(32)) bus ();

  csr_access_unit #(.XLEN(32)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR register file model
  logic [31:0] csr_mem [0:4095];
  assign bus.csr_rdata_i = csr_mem[bus.csr_idx_o];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) csr_mem[i] <= 32'h0;
      csr_mem[12'h340] <= 32'h0000_00F0;
      csr_mem[12'h305] <= 32'h0000_0100;
      csr_mem[12'hF11] <= 32'h0000_1234;
    end else if (bus.csr_wr_en_o === 1'b1) begin
      csr_mem[bus.csr_idx_o] <= bus.csr_wdata_o;
    end
  end

  // Strobe monitor
  always @(negedge clk) begin
    if (bus.csr_wr_en_o === 1'b1) begin
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= bus.csr_wdata_o;
    end
    if (bus.csr_rd_en_o === 1'b1) rd_cnt <= rd_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outcome of one instruction, from the instruction rules
  typedef struct {
    logic        rd;
    logic        wr;
    logic        ill;
    logic [11:0] addr;
    logic [31:0] old;
    logic [31:0] newv;
    int          lat;
  } txn_t;

  function automatic logic is_impl(input logic [11:0] a);
    case (a)
      12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300, 12'h301, 12'h304, 12'h305,
      12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
      12'hBB2, 12'h320: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic txn_t model_txn(input logic [2:0] f3, input logic [11:0] a,
                                     input logic [31:0] d, input logic [4:0] fld,
                                     input logic rdz);
    txn_t t;
    logic bad;
    logic rw;
    logic [31:0] opnd;
    bad  = (f3 == 3'b000) || (f3 == 3'b100);
    rw   = (f3 == 3'b001) || (f3 == 3'b101);
    opnd = f3[2] ? {27'h0, fld} : d;
    t.addr = a;
    t.wr   = !bad && (rw || fld != 5'd0);
    t.ill  = bad;
`ifdef CSR_ACCESS_CHECK_EN
    if (!is_impl(a) || (t.wr && a >= 12'hC00)) t.ill = 1'b1;
`endif
    if (t.ill) begin
      t.rd = 1'b0;
      t.wr = 1'b0;
    end else begin
      t.rd = !(rw && rdz);
    end
    t.old = t.rd ? csr_mem[a] : 32'h0;
    if (rw)                                      t.newv = opnd;
    else if ((f3 == 3'b010) || (f3 == 3'b110))   t.newv = t.old | opnd;
    else                                         t.newv = t.old & ~opnd;
    t.lat = t.wr ? 3 : 2;
    return t;
  endfunction

  // Timeline model: m_k counts edges since accept (1 = read cycle)
  txn_t m_t;
  logic m_busy;
  logic m_zero;
  int   m_k;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_zero <= 1'b1;
    end else if (!m_busy) begin
      if (bus.req_valid_i) begin
        m_t    <= model_txn(bus.req_funct3_i, bus.req_addr_i, bus.req_rs1_data_i,
                            bus.req_rs1_field_i, bus.req_rd_zero_i);
        m_busy <= 1'b1;
        m_k    <= 1;
        m_zero <= 1'b0;
      end
    end else if (m_k >= m_t.lat && bus.rsp_ready_i) begin
      m_busy <= 1'b0;
    end else if (m_k < 1000) begin
      m_k <= m_k + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(bus.req_ready_o), 32'(!m_busy));
      chk("csr_rd_en", 32'(bus.csr_rd_en_o), 32'(m_busy && m_k == 1 && m_t.rd));
      chk("csr_wr_en", 32'(bus.csr_wr_en_o), 32'(m_busy && m_k == 2 && m_t.wr));
      chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(m_busy && m_k >= m_t.lat));
      if (m_busy && ((m_k == 1 && m_t.rd) || (m_k == 2 && m_t.wr)))
        chk("csr_idx", 32'(bus.csr_idx_o), 32'(m_t.addr));
      if (m_busy && m_k == 2 && m_t.wr)
        chk("csr_wdata", bus.csr_wdata_o, m_t.newv);
      if (m_busy && m_k >= m_t.lat) begin
        chk("rsp_rdata", bus.rsp_rdata_o, m_t.old);
        chk("rsp_illegal", 32'(bus.rsp_illegal_o), 32'(m_t.ill));
      end
      if (m_zero) begin
        chk("rst_csr_idx", 32'(bus.csr_idx_o), 32'h0);
        chk("rst_csr_wdata", bus.csr_wdata_o, 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata_o, 32'h0);
        chk("rst_rsp_illegal", 32'(bus.rsp_illegal_o), 32'h0);
      end
    end
  end

  // Issue one request starting at a falling edge; returns at a falling edge, idle
  task automatic do_txn(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                        input logic [4:0] fld, input logic rdz, input int hold,
                        output int acc_wait, output int lat, output logic [31:0] rdata,
                        output logic ill, output int nrd, output int nwr);
    txn_t t;
    int rd0;
    int wr0;
    t   = model_txn(f3, a, d, fld, rdz);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    bus.req_funct3_i    = f3;
    bus.req_addr_i      = a;
    bus.req_rs1_data_i  = d;
    bus.req_rs1_field_i = fld;
    bus.req_rd_zero_i   = rdz;
    bus.req_valid_i     = 1'b1;
    acc_wait = 0;
    do begin
      @(negedge clk);
      acc_wait++;
    end while (!(m_busy && m_k == 1) && acc_wait < 20);
    bus.req_valid_i = 1'b0;
    chk("accept_wait", 32'(acc_wait), 32'd1);
    lat = 1;
    while (bus.rsp_valid_o !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(t.lat));
    rdata = bus.rsp_rdata_o;
    ill   = bus.rsp_illegal_o;
    chk("rdata_vs_model", rdata, t.old);
    chk("illegal_vs_model", 32'(ill), 32'(t.ill));
    repeat (hold) @(negedge clk);
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    nrd = rd_cnt - rd0;
    nwr = wr_cnt - wr0;
    chk("rd_strobes", 32'(nrd), 32'(t.rd));
    chk("wr_strobes", 32'(nwr), 32'(t.wr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t        t;
    int          aw;
    int          lat;
    int          nrd;
    int          nwr;
    int          w0;
    logic [31:0] rd;
    logic        il;

    checks = 0; errors = 0; rd_cnt = 0; wr_cnt = 0; last_wdata = 32'h0;
    rst = 1'b1; preload = 1'b1; chk_en = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_funct3_i = 3'b000; bus.req_addr_i = 12'h0;
    bus.req_rs1_data_i = 32'h0; bus.req_rs1_field_i = 5'd0; bus.req_rd_zero_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    preload = 1'b0; rst = 1'b0; chk_en = 1'b1;
    chk("reset_req_ready", 32'(bus.req_ready_o), 32'h1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);

    // CSRRC with zero rs1 field: read only, no write
    t = model_txn(3'b011, 12'h340, 32'hFF, 5'd0, 1'b0);
    chk("model_rc0_old", t.old, 32'hF0);
    do_txn(3'b011, 12'h340, 32'hFF, 5'd0, 1'b0, 0, aw, lat, rd, il, nrd, nwr);
    chk("rc0_rdata", rd, 32'hF0);
    chk("rc0_lat", 32'(lat), 32'd2);
    chk("rc0_wr", 32'(nwr), 32'd0);

    // CSRRS mscratch |= 0x0F
    t = model_txn(3'b010, 12'h340, 32'h0F, 5'd5, 1'b0);
    chk("model_rs_new", t.newv, 32'hFF);
    do_txn(3'b010, 12'h340, 32'h0F, 5'd5, 1'b0, 0, aw, lat, rd, il, nrd, nwr);
    chk("rs_rdata", rd, 32'hF0);
    chk("rs_lat", 32'(lat), 32'd3);
    chk("rs_wdata", last_wdata, 32'hFF);
    chk("rs_mem", csr_mem[12'h340], 32'hFF);

    // CSRRWI to x0: read suppressed
    do_txn(3'b101, 12'h305, 32'hDEAD, 5'h1F, 1'b1, 0, aw, lat, rd, il, nrd, nwr);
    chk("rwi_rd", 32'(nrd), 32'd0);
    chk("rwi_wdata", last_wdata, 32'h1F);
    chk("rwi_rdata", rd, 32'h0);

    // Response held off for 5 cycles, then back-to-back request
    do_txn(3'b010, 12'h340, 32'h100, 5'd3, 1'b0, 5, aw, lat, rd, il, nrd, nwr);
    chk("hold_rdata", rd, 32'hFF);
    do_txn(3'b011, 12'h340, 32'h0F, 5'd7, 1'b0, 0, aw, lat, rd, il, nrd, nwr);
    chk("b2b_accept", 32'(aw), 32'd1);
    chk("b2b_rdata", rd, 32'h1FF);
    chk("b2b_mem", csr_mem[12'h340], 32'h1F0);

    // Reset during the read cycle of a CSRRW
    w0 = wr_cnt;
    bus.req_funct3_i = 3'b001; bus.req_addr_i = 12'h340; bus.req_rs1_data_i = 32'h55;
    bus.req_rs1_field_i = 5'd1; bus.req_rd_zero_i = 1'b0; bus.req_valid_i = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("rst_mid_in_read", 32'(bus.csr_rd_en_o), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", 32'(bus.req_ready_o), 32'h1);
    chk("rst_mid_idx", 32'(bus.csr_idx_o), 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_write", 32'(wr_cnt - w0), 32'h0);
    chk("rst_mid_mem", csr_mem[12'h340], 32'h1F0);

    // CSRRW to a read-only CSR
    do_txn(3'b001, 12'hF11, 32'h77, 5'd2, 1'b0, 0, aw, lat, rd, il, nrd, nwr);
`ifdef CSR_ACCESS_CHECK_EN
    chk("ro_illegal", 32'(il), 32'h1);
    chk("ro_strobes", 32'(nrd + nwr), 32'h0);
    chk("ro_rdata", rd, 32'h0);
`else
    chk("ro_illegal", 32'(il), 32'h0);
    chk("ro_wr", 32'(nwr), 32'h1);
    chk("ro_rdata", rd, 32'h1234);
    chk("ro_wdata", last_wdata, 32'h77);
`endif

    // funct3 = 100
    do_txn(3'b100, 12'h340, 32'h5, 5'd5, 1'b0, 1, aw, lat, rd, il, nrd, nwr);
    chk("f3_100_illegal", 32'(il), 32'h1);
    chk("f3_100_rdata", rd, 32'h0);
    chk("f3_100_lat", 32'(lat), 32'd2);
    chk("f3_100_strobes", 32'(nrd + nwr), 32'h0);

    // CSRRSI with zimm 0: read only
    do_txn(3'b110, 12'h340, 32'hFFFF, 5'd0, 1'b0, 0, aw, lat, rd, il, nrd, nwr);
    chk("rsi0_rdata", rd, 32'h1F0);
    chk("rsi0_wr", 32'(nwr), 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
